spi_flash_responder: RTL

Synthesizable SPI flash responder: the device end of the single-lane 0x03 READ transaction that our SPI flash read controller issues. It decodes the command and 24-bit address from `mosi` and serves bytes MSB-first on `miso` from a local byte-wide memory port. Bytes stream continuously with address auto-increment until chip select rises. It is used as an on-chip flash emulator, and as the flash model in system-level benches.

---
 rtl/spi_flash_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI flash responder: device end of a single-lane 0x03 READ, mode 3.
// Decodes command and 24-bit address from mosi, then streams bytes on miso.
// Ports: clk/rstn (async, active high), sclk/cs/mosi pins in, miso/miso_oe
// out, mem_req/mem_addr/mem_ack/mem_rdata byte memory port, and
// busy/cmd_err/underrun status.
module spi_flash_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        cmd_err,
  output logic        underrun
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, IGNORE
  } state_t;

  localparam int L = SYNC_STAGES - 1;

  state_t            state;
  logic [L:0]        sclk_sy;
  logic [L:0]        cs_sy;
  logic [L:0]        mosi_sy;
  logic              sclk_q;
  logic              cs_q;
  logic [22:0]       sh;
  logic [4:0]        bcnt;
  logic [2:0]        dcnt;
  logic [7:0]        dout;
  logic [7:0]        pbuf;
  logic              buf_full;
  logic [23:0]       addr;
  logic              fetch_pend;
  logic              discard;

  logic              s_sclk;
  logic              s_cs;
  logic              rise;
  logic              fall;
  logic              cs_rise;
  logic              cs_fall;
  logic [23:0]       shin;
  logic              ack_ok;
  logic              avail;
  logic [7:0]        nbyte;
  logic              boundary;
  logic              addr_done;
  logic              req_go;
  logic [23:0]       go_addr;

  // Pins idle high, so the synchronizers reset to 1 to avoid false edges.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sclk_sy <= '1;
      cs_sy   <= '1;
      mosi_sy <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[L-1:0], sclk};
      cs_sy   <= {cs_sy[L-1:0], cs};
      mosi_sy <= {mosi_sy[L-1:0], mosi};
      sclk_q  <= sclk_sy[L];
      cs_q    <= cs_sy[L];
    end
  end

  always_comb begin
    s_sclk  = sclk_sy[L];
    s_cs    = cs_sy[L];
    // sclk edges only count while cs is low; a cs rise masks them.
    rise    = s_sclk & ~sclk_q & ~s_cs;
    fall    = ~s_sclk & sclk_q & ~s_cs;
    cs_rise = s_cs & ~cs_q;
    cs_fall = ~s_cs & cs_q;
    shin    = {sh, mosi_sy[L]};
    // An ack landing on a byte boundary is used directly.
    ack_ok  = mem_ack & mem_req & ~discard;
    avail   = buf_full | ack_ok;
    nbyte   = buf_full ? pbuf : mem_rdata;
    boundary  = (state == DATA) & fall
              & (dcnt == 3'd7);
    addr_done = (state == ADDR) & rise
              & (bcnt == 5'd0);
    req_go  = ~mem_req & (addr_done
            | ((fetch_pend | boundary)
               & (state == DATA) & ~s_cs));
    go_addr = addr_done ? shin : addr;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      underrun   <= 1'b0;
      sh         <= '0;
      bcnt       <= '0;
      dcnt       <= '0;
      dout       <= '0;
      pbuf       <= '0;
      buf_full   <= 1'b0;
      addr       <= '0;
      fetch_pend <= 1'b0;
      discard    <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (!discard) begin
          pbuf     <= mem_rdata;
          buf_full <= 1'b1;
        end
      end
      if (req_go) begin
        mem_req    <= 1'b1;
        mem_addr   <= go_addr;
        addr       <= go_addr + 24'd1;
        fetch_pend <= 1'b0;
        discard    <= 1'b0;
      end
      if (cs_rise) begin
        state      <= IDLE;
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
        busy       <= 1'b0;
        fetch_pend <= 1'b0;
        buf_full   <= 1'b0;
        // A request still in flight completes, but its data is dropped.
        if (mem_req && !mem_ack) discard <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              bcnt     <= 5'd7;
              cmd_err  <= 1'b0;
              underrun <= 1'b0;
              busy     <= 1'b1;
            end
          end
          CMD: begin
            if (rise) begin
              sh <= shin[22:0];
              if (bcnt == 5'd0) begin
                if (shin[7:0] == 8'h03) begin
                  state <= ADDR;
                  bcnt  <= 5'd23;
                end else begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bcnt <= bcnt - 5'd1;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              sh <= shin[22:0];
              if (bcnt == 5'd0) begin
                state <= DATA;
                dcnt  <= 3'd7;
                // Blocked by an old request: fetch once it is acked.
                if (!req_go) begin
                  addr       <= shin;
                  fetch_pend <= 1'b1;
                end
              end else begin
                bcnt <= bcnt - 5'd1;
              end
            end
          end
          DATA: begin
            if (fall) begin
              miso_oe <= 1'b1;
              dcnt    <= dcnt - 3'd1;
              if (boundary) begin
                miso     <= avail & nbyte[7];
                dout     <= avail ? {nbyte[6:0], 1'b0}
                                  : 8'h00;
                buf_full <= 1'b0;
                if (!avail) underrun <= 1'b1;
                if (!req_go) begin
                  fetch_pend <= 1'b1;
                  // Skipped byte: move on past it.
                  if (fetch_pend) addr <= addr + 24'd1;
                  if (mem_req && !mem_ack) discard <= 1'b1;
                end
              end else begin
                miso <= dout[7];
                dout <= {dout[6:0], 1'b0};
              end
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
